instr_loader: RTL and testbench

Byte-stream program loader; the writer side of the instruction memory that the control unit reads through read_file/fin_file.
- Accepts a length-prefixed byte stream over a valid/ready handshake.
- Assembles big-endian 16-bit instruction words and writes them into consecutive instruction memory locations starting at 0.
- Raises fin_file when the image is complete, which releases the control unit to start fetching.

---
 rtl/instr_loader.sv | 183 ++++++++++++++++++
 tb/tb_instr_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream program loader: length-prefixed, big-endian 16-bit imem writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bgn,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              fin_file,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  state_t            end_st;
  logic [7:0]        n_hi_q, n_hi_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        hi_q, hi_d;
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              fin_q, fin_d;
  logic              err_q, err_d;
  logic              xfer;
  logic [15:0]       len;
  logic [31:0]       wc_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    n_hi_d    = n_hi_q;
    n_d       = n_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wc_d      = wc_q;
    xfer      = byte_valid && byte_ready_q;
    len       = {n_hi_q, byte_in};
    wc_inc    = 32'(wc_q) + 32'd1;
`ifdef LOADER_CHECKSUM_EN
    end_st = S_CSUM;
    csum_d = csum_q;
    if (xfer) csum_d = csum_q ^ byte_in;
`else
    end_st = S_DONE;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bgn) begin
          state_d = S_LEN_HI;
          wc_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          n_hi_d  = byte_in;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = len;
          // oversize images are refused before any write
          unique case (1'b1)
            (len == 16'd0):             state_d = end_st;
            (32'(len) > 32'(DEPTH)):    state_d = S_ERR;
            default:                    state_d = S_DATA_HI;
          endcase
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_d    = byte_in;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = wc_q[ADDR_W-1:0];
          wr_data_d = WORD_W'({hi_q, byte_in});
        end
      end
      S_WRITE: begin
        wc_d    = wc_q + {{ADDR_W{1'b0}}, 1'b1};
        state_d = (wc_inc == 32'(n_q)) ? end_st : S_DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // status outputs are registered decodes of the next state
    byte_ready_d = 1'b0;
    case (state_d)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: byte_ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: byte_ready_d = 1'b1;
`endif
      default: byte_ready_d = 1'b0;
    endcase
    fin_d = (state_d == S_DONE);
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_hi_q       <= '0;
      n_q          <= '0;
      hi_q         <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wc_q         <= '0;
      fin_q        <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_hi_q       <= n_hi_d;
      n_q          <= n_d;
      hi_q         <= hi_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wc_q         <= wc_d;
      fin_q        <= fin_d;
      err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = wc_q;
  assign fin_file   = fin_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: vector table, hand sequences, random loads vs model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_instr_loader;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int WORD_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              bgn;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [ADDR_W:0]   word_count;
  logic              fin_file;
  logic              err;

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .bgn(bgn),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .fin_file(fin_file), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] bytes;
    int          len;
    int          gap;
    bit          rb;
    bit          e_fin;
    bit          e_err;
    int          e_wc;
    int          e_nwr;
    logic [15:0] e_last;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int                cyc = 0;
  int                fin_cyc = 0;
  int                dbl = 0;
  logic              fin_prev = 1'b0;
  logic              wr_prev = 1'b0;
  logic [ADDR_W-1:0] cap_addr[$];
  logic [WORD_W-1:0] cap_data[$];
  int                cap_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cyc);
      if (wr_prev) dbl++;
    end
    if (fin_file && !fin_prev) fin_cyc = cyc;
    fin_prev = fin_file;
    wr_prev  = wr_en;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, 32'(byte_ready), 0);
    chk({p, "_wr_en"}, 32'(wr_en), 0);
    chk({p, "_wr_addr"}, 32'(wr_addr), 0);
    chk({p, "_wr_data"}, 32'(wr_data), 0);
    chk({p, "_wc"}, 32'(word_count), 0);
    chk({p, "_fin"}, 32'(fin_file), 0);
    chk({p, "_err"}, 32'(err), 0);
  endtask

  task automatic pulse_bgn();
    bgn = 1'b1;
    @(negedge clk);
    bgn = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit rb, output bit ok);
    bit take;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      byte_valid = ($urandom_range(99) >= gap);
      byte_in    = byte_valid ? b : 8'($urandom);
      bgn        = rb ? 1'($urandom_range(1)) : 1'b0;
      take       = byte_valid && byte_ready;
      @(negedge clk);
      ok = take;
    end
    byte_valid = 1'b0;
    bgn        = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    for (int k = 0; k < 20 && !(fin_file || err); k++) @(negedge clk);
    ok = fin_file || err;
    if (!ok) chk("end_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_load(input logic [7:0] s[$], input int gap,
                          input bit rb, output bit ok);
    pulse_bgn();
    foreach (s[i]) begin
      send_byte(s[i], gap, rb, ok);
      if (!ok) begin
        chk("xfer_timeout", 0, 1);
        return;
      end
    end
    wait_end(ok);
  endtask

  task automatic model(input logic [7:0] s[$], output bit e_fin,
                       output bit e_err, output int e_wc,
                       output logic [15:0] e_w[$]);
    int n;
    logic [7:0] x;
    e_w.delete();
    e_fin = 1'b0;
    e_err = 1'b0;
    e_wc  = 0;
    n = {s[0], s[1]};
    if (n > DEPTH) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) e_w.push_back({s[2+2*i], s[3+2*i]});
    e_wc = n;
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * n; i++) x ^= s[i];
    if (s[2+2*n] == x) e_fin = 1'b1;
    else e_err = 1'b1;
`else
    x = 8'h00;
    e_fin = 1'b1;
`endif
  endtask

  task automatic check_load(input string nm, input logic [7:0] s[$],
                            input int gap, input bit rb);
    bit ok, e_fin, e_err;
    int e_wc, base, nwr;
    logic [15:0] e_w[$];
    base = cap_addr.size();
    run_load(s, gap, rb, ok);
    if (!ok) return;
    model(s, e_fin, e_err, e_wc, e_w);
    nwr = cap_addr.size() - base;
    chk({nm, "_fin"}, 32'(fin_file), 32'(e_fin));
    chk({nm, "_err"}, 32'(err), 32'(e_err));
    chk({nm, "_wc"}, 32'(word_count), 32'(e_wc));
    chk({nm, "_nwr"}, 32'(nwr), 32'(e_w.size()));
    for (int i = 0; i < nwr && i < e_w.size(); i++) begin
      chk({nm, "_addr"}, 32'(cap_addr[base+i]), 32'(i));
      chk({nm, "_data"}, 32'(cap_data[base+i]), 32'(e_w[i]));
    end
  endtask

  function automatic vec_t mk(logic [95:0] b, int len, int gap, bit rb,
                              bit f, bit e, int wc, int nwr,
                              logic [15:0] last);
    vec_t v;
    v.bytes = b; v.len = len; v.gap = gap; v.rb = rb;
    v.e_fin = f; v.e_err = e; v.e_wc = wc; v.e_nwr = nwr; v.e_last = last;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [7:0] s[$];
    bit ok;
    int base, nwr, n;
    logic [7:0] x;

`ifdef LOADER_CHECKSUM_EN
    tbl.push_back(mk({72'h0003_1234_ABCD_0FF0_BC, 24'h0}, 9, 0, 0,
                     1, 0, 3, 3, 16'h0FF0));
    tbl.push_back(mk({24'h000000, 72'h0}, 3, 0, 0, 1, 0, 0, 0, 16'h0));
    tbl.push_back(mk({24'h000001, 72'h0}, 3, 0, 0, 0, 1, 0, 0, 16'h0));
    tbl.push_back(mk({16'h0201, 80'h0}, 2, 0, 0, 0, 1, 0, 0, 16'h0));
    tbl.push_back(mk({40'h0001_BEEF_50, 56'h0}, 5, 50, 1,
                     1, 0, 1, 1, 16'hBEEF));
    tbl.push_back(mk({40'h0001_1234_27, 56'h0}, 5, 0, 0,
                     1, 0, 1, 1, 16'h1234));
    tbl.push_back(mk({40'h0001_1234_26, 56'h0}, 5, 0, 0,
                     0, 1, 1, 1, 16'h1234));
`else
    tbl.push_back(mk({64'h0003_1234_ABCD_0FF0, 32'h0}, 8, 0, 0,
                     1, 0, 3, 3, 16'h0FF0));
    tbl.push_back(mk({16'h0000, 80'h0}, 2, 0, 0, 1, 0, 0, 0, 16'h0));
    tbl.push_back(mk({16'h0201, 80'h0}, 2, 0, 0, 0, 1, 0, 0, 16'h0));
    tbl.push_back(mk({32'h0001_BEEF, 64'h0}, 4, 50, 1,
                     1, 0, 1, 1, 16'hBEEF));
    tbl.push_back(mk({48'h0002_CAFE_0001, 48'h0}, 6, 30, 1,
                     1, 0, 2, 2, 16'h0001));
`endif

    rst = 1'b1; bgn = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[t]) begin
      s.delete();
      for (int i = 0; i < tbl[t].len; i++)
        s.push_back(tbl[t].bytes[95-8*i -: 8]);
      base = cap_addr.size();
      run_load(s, tbl[t].gap, tbl[t].rb, ok);
      if (!ok) continue;
      nwr = cap_addr.size() - base;
      chk("tbl_fin", 32'(fin_file), 32'(tbl[t].e_fin));
      chk("tbl_err", 32'(err), 32'(tbl[t].e_err));
      chk("tbl_wc", 32'(word_count), 32'(tbl[t].e_wc));
      chk("tbl_nwr", 32'(nwr), 32'(tbl[t].e_nwr));
      chk("tbl_ready_end", 32'(byte_ready), 0);
      if (nwr > 0 && nwr == tbl[t].e_nwr) begin
        chk("tbl_last_addr", 32'(cap_addr[$]), 32'(nwr - 1));
        chk("tbl_last_data", 32'(cap_data[$]), 32'(tbl[t].e_last));
        chk("tbl_first_addr", 32'(cap_addr[base]), 0);
`ifndef LOADER_CHECKSUM_EN
        chk("tbl_fin_lat", 32'(fin_cyc - cap_cyc[$]), 1);
`endif
        if (tbl[t].gap == 0 && nwr > 1)
          chk("tbl_word_rate", 32'(cap_cyc[$] - cap_cyc[$-1]), 3);
      end
    end

    // restart out of ERR
    s.delete(); s.push_back(8'h02); s.push_back(8'h01);
    run_load(s, 0, 0, ok);
    chk("err_set", 32'(err), 1);
    pulse_bgn();
    chk("err_restart_ready", 32'(byte_ready), 1);
    chk("err_restart_err", 32'(err), 0);
    s.delete(); s.push_back(8'h00); s.push_back(8'h00);
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    foreach (s[i]) send_byte(s[i], 0, 0, ok);
    wait_end(ok);
    chk("err_restart_fin", 32'(fin_file), 1);

    // reset after the first of three words
    pulse_bgn();
    s.delete();
    s = '{8'h00, 8'h03, 8'h11, 8'h22};
    foreach (s[i]) send_byte(s[i], 0, 0, ok);
    chk("mid_wr_en", 32'(wr_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("mid_rst");
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h00 ^ 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66);
`endif
    check_load("reload", s, 0, 0);

    // exactly DEPTH words
    s.delete(); s.push_back(8'(DEPTH >> 8)); s.push_back(8'(DEPTH));
    for (int i = 0; i < 2 * DEPTH; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (s[i]) x ^= s[i];
    s.push_back(x);
`endif
    check_load("full", s, 0, 0);

    for (int it = 0; it < 25; it++) begin
      int r;
      r = $urandom_range(9);
      if (r == 0) n = 0;
      else if (r == 1) n = DEPTH + 1 + $urandom_range(200);
      else n = $urandom_range(6, 1);
      s.delete(); s.push_back(8'(n >> 8)); s.push_back(8'(n));
      if (n <= DEPTH) begin
        for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (s[i]) x ^= s[i];
        if ($urandom_range(3) == 0) x ^= 8'($urandom_range(255, 1));
        s.push_back(x);
`endif
      end
      check_load("rand", s, $urandom_range(60), 1'($urandom_range(1)));
    end

    chk("wr_en_single_cycle", 32'(dbl), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
